// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: widths, reset vector, NOP
// encoding and the instruction/PC pair carried by the fetch buffer.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] pc;
  } ifetch_entry_t;

endpackage

// File: rtl/mips_ifetch_buffer_if.sv
// Fetch-buffer bus: redirect from the core, imem req/gnt/rvalid channel,
// and the valid/ready instruction stream toward the core.
// master = the fetch buffer, slave = core + instruction memory side.
interface mips_ifetch_buffer_if #(
  parameter int DATA_W = mips_pkg::DATA_W
);

  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module mips_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is still fine when the head leaves this cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents need no reset since validity lives in count_q.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Underflow guard: the consumer must never pop an empty FIFO.
  always_ff @(posedge clk) begin
    if (!rst_i && !flush_i) begin
      assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/mips_ifetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, tracks
// outstanding responses against FIFO credit, drops responses that belong
// to fetches made before a redirect, and hands {inst, pc} to the core.
module mips_ifetch_buffer
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,   // active-high synchronous reset
  mips_ifetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * DATA_W;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;

  logic [CW:0]       credit_used;
  logic              req_acc;
  logic [DATA_W-1:0] redirect_pc_aligned;

  // Every buffered entry and every in-flight fetch holds one FIFO slot, so a
  // response always has room even if the core stalls indefinitely.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign bus.imem_req = !rst_n && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc_q;
  assign req_acc      = bus.imem_req && bus.imem_gnt;

  assign redirect_pc_aligned = bus.redirect_pc & ~DATA_W'(3);

  // Responses still owed to pre-redirect fetches are swallowed; a response
  // arriving in the redirect cycle itself is stale by definition.
  assign fifo_push = bus.imem_rvalid && (discard_q == '0) && !bus.redirect_valid;
  assign fifo_pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign fifo_din  = {bus.imem_rdata, resp_pc_q};

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_empty ? DATA_W'(NOP_INST) : fifo_dout[EW-1:DATA_W];
  assign bus.inst_pc    = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];

  mips_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_n),
    .flush_i (bus.redirect_valid),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state for fetch/response PCs, in-flight count and discard count.
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_acc) - CW'(bus.imem_rvalid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      // Everything still in flight after this cycle predates the redirect.
      discard_d  = outstanding_d;
    end else begin
      if (req_acc)   fetch_pc_d = fetch_pc_q + DATA_W'(4);
      if (fifo_push) resp_pc_d  = resp_pc_q + DATA_W'(4);
      if (bus.imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Overflow guard: the credit check must leave a slot for every response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end

endmodule

// File: doc/mips_ifetch_buffer.md
Name: mips_ifetch_buffer

Overview:
- Instruction prefetch stage feeding the MIPS single-cycle core.
- Issues sequential word fetches to a variable-latency instruction memory over a req/gnt + rvalid protocol.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the core via valid/ready.
- Accepts redirects (branch/jump/exception) from the core: flushes buffered and in-flight fetches and restarts at the new PC.

Parameters:
- DATA_W, 32, instruction and address width.
- DEPTH, 4, FIFO entries; also the cap on (buffered + outstanding) fetches; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-high (asserted = 1). Name kept for codebase consistency.
- redirect_valid  input  1  core requests a fetch restart.
- redirect_pc  input  DATA_W  restart address; bits [1:0] forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  DATA_W  fetch address (word aligned).
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  input  DATA_W  instruction word.
- inst_valid  output  1  FIFO head valid.
- inst  output  DATA_W  head instruction.
- inst_pc  output  DATA_W  head instruction PC.
- inst_ready  input  1  core consumes the head this cycle.

Behaviour:
- Reset (rst_n=1 at clk edge) sets:
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - inst_valid=0, inst=0, inst_pc=0, imem_req=0 in the reset cycle.
- Request: imem_req = !rst_n & !redirect_valid & (count + outstanding < DEPTH). imem_addr = fetch_pc (registered).
- Request acceptance (req & gnt): fetch_pc += 4, wrapping modulo 2^DATA_W. outstanding += 1.
- Withdrawal: imem_req may drop without gnt (e.g. on redirect); the memory does not latch ungranted requests.
- Response: each rvalid decrements outstanding.
  - If discard>0: discard -= 1 and data is dropped.
  - Otherwise: push {rdata, pc_of_response} into the FIFO. The response PC comes from a PC queue captured at gnt, or equivalently from a resp_pc register advanced by 4 per kept response.
- Latency: rvalid at cycle t -> inst_valid at t+1 (registered FIFO, no bypass).
  - First instruction after reset release: inst_valid no earlier than 3 cycles (req/gnt cycle, rvalid cycle, output cycle).
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle while full: both succeed, count unchanged.
- Overflow cannot occur: the credit check guarantees a FIFO slot for every outstanding response. An assertion checks push while full without pop.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed; a pop in the same cycle has no additional effect.
  - imem_req=0 that cycle. fetch_pc <= redirect_pc & ~3.
  - discard <= outstanding (counted after the gnt/rvalid of this cycle). An rvalid in the redirect cycle is dropped.
  - Resp PC tracking reloads to redirect_pc.
  - inst_valid=0 the following cycle. The new fetch is requested the cycle after redirect.
- Back-to-back redirects: the latest one wins; discard accumulates correctly.
- Fetching during discard: new requests may issue while discard>0, within the credit limit. In-order return makes the discard count sufficient.
- Counter widths: count and outstanding are clog2(DEPTH)+1 bits; neither can exceed DEPTH.
- Reset mid-operation: all state cleared. Responses for pre-reset requests are the memory's responsibility (the memory is reset on the same rst_n).

Decomposition:
- Shared package mips_pkg: DATA_W, RESET_PC, NOP encoding (32'h0000_0000), and an ifetch entry struct {inst, pc}.
- One sub-module: mips_sync_fifo, a parameterised-width/depth synchronous FIFO with flush input, count output, full/empty.
- Credit logic, redirect/discard logic, and PC tracking stay in the top module.

Test Plan:
- Reset release, gnt=1, 1-cycle latency, inst_ready=1 -> inst_pc sequence 0,4,8,12… on consecutive cycles after the first valid at cycle 3, inst equal to the memory contents.
- inst_ready=0 held -> exactly DEPTH=4 requests granted (0x0–0xC), then imem_req=0. Raise ready -> 4 pops in order, then fetch resumes at 0x10.
- Redirect to 0x103 with 3 fetches outstanding (latency 4) -> imem_addr=0x100 next cycle, the 3 stale responses are dropped, and the first inst_pc after the redirect is 0x100.
- Redirect in the same cycle as rvalid and inst_ready -> that response is not delivered, inst_valid=0 next cycle, no FIFO underflow or overflow assertion fires.
- fetch_pc at 0xFFFF_FFFC -> next request address is 0x0000_0000.
- rst_n pulsed for 1 cycle while the FIFO holds 2 entries -> inst_valid=0 next cycle, then the next request is at RESET_PC.
